// File: rtl/kc705_ethernet_rgmii_axi_tx_arbiter.sv
// Frame-level 2:1 arbiter for the shared 8-bit AXI-Stream Ethernet TX path.
// Port 0 carries ADC packetizer frames, port 1 carries command-reply frames.
// Only whole frames are granted. An idle gap follows every frame. Frames
// longer than MAX_FRAME bytes are cut with a forced tlast, and their tail is
// drained from the source.
//
// Ports:
//   axi_tclk, axi_treset    clock and synchronous active-high reset
//   enable_tx_arb           allows new grants; a frame in progress always completes
//   s0_axis_*, s1_axis_*    source streams (tdata/tvalid/tlast in, tready out)
//   tx_axis_*               stream to the TX MAC (combinational mux of the granted port)
//   grant                   registered one-hot active grant, [0] = port 0
//   frame_trunc             registered 1-cycle pulse when a frame is truncated
//   frames_s0, frames_s1    registered completed-frame counters, wrapping
module kc705_ethernet_rgmii_axi_tx_arbiter #(
    parameter logic        ARB_MODE   = 1'b0,
    parameter logic [7:0]  IFG_CYCLES = 8'd12,
    parameter logic [15:0] MAX_FRAME  = 16'd1518
) (
    input  logic        axi_tclk,
    input  logic        axi_treset,
    input  logic        enable_tx_arb,
    input  logic [7:0]  s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    output logic        s0_axis_tready,
    input  logic [7:0]  s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    output logic        s1_axis_tready,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    output logic        tx_axis_tlast,
    input  logic        tx_axis_tready,
    output logic [1:0]  grant,
    output logic        frame_trunc,
    output logic [15:0] frames_s0,
    output logic [15:0] frames_s1
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IFG_W  = 8;

    localparam logic [CNT_W-1:0] BYTE_LAST = MAX_FRAME - CNT_W'(1);
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_CYCLES - IFG_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              valid;
    } beat_t;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, IFG} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic [CNT_W-1:0]   byte_cnt;
    logic [IFG_W-1:0]   ifg_cnt;

    beat_t              sel_beat;
    logic               sel_ready;
    logic               pick_port;
    logic               at_max;
    logic               grant_load;
    logic               beat_hs;
    logic               frame_done;
    logic               drain_done;
    logic               trunc_c;

    // Granted source; grant[1] selects port 1, otherwise port 0.
    always_comb begin
        if (grant[1]) begin
            sel_beat = '{data: s1_axis_tdata, last: s1_axis_tlast, valid: s1_axis_tvalid};
        end else begin
            sel_beat = '{data: s0_axis_tdata, last: s0_axis_tlast, valid: s0_axis_tvalid};
        end
    end

    assign at_max = (byte_cnt == BYTE_LAST);

    // Winner of the next grant decision.
    always_comb begin
        pick_port = 1'b0;
        if (ARB_MODE) begin
            pick_port = ~s0_axis_tvalid;
        end else if (s0_axis_tvalid && s1_axis_tvalid) begin
            pick_port = ~last_grant;
        end else begin
            pick_port = s1_axis_tvalid;
        end
    end

    // State register.
    always_ff @(posedge axi_tclk) begin
        if (axi_treset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stream mux and per-cycle control strobes.
    always_comb begin
        state_nxt      = state;
        tx_axis_tdata  = '0;
        tx_axis_tvalid = 1'b0;
        tx_axis_tlast  = 1'b0;
        sel_ready      = 1'b0;
        grant_load     = 1'b0;
        beat_hs        = 1'b0;
        frame_done     = 1'b0;
        drain_done     = 1'b0;
        trunc_c        = 1'b0;
        case (state)
            IDLE: begin
                if (enable_tx_arb && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    grant_load = 1'b1;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                tx_axis_tdata  = sel_beat.data;
                tx_axis_tvalid = sel_beat.valid;
                tx_axis_tlast  = sel_beat.last | at_max;
                sel_ready      = tx_axis_tready;
                if (sel_beat.valid && tx_axis_tready) begin
                    beat_hs = 1'b1;
                    // A source tlast on the last allowed byte is a normal completion.
                    if (sel_beat.last) begin
                        frame_done = 1'b1;
                        state_nxt  = IFG;
                    end else if (at_max) begin
                        trunc_c   = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                sel_ready = 1'b1;
                if (sel_beat.valid && sel_beat.last) begin
                    drain_done = 1'b1;
                    state_nxt  = IFG;
                end
            end
            IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign s0_axis_tready = sel_ready & grant[0];
    assign s1_axis_tready = sel_ready & grant[1];

    // Grant, byte/gap counters, truncation pulse and frame counters.
    always_ff @(posedge axi_tclk) begin
        if (axi_treset) begin
            grant       <= '0;
            last_grant  <= 1'b1;
            byte_cnt    <= '0;
            ifg_cnt     <= '0;
            frame_trunc <= 1'b0;
            frames_s0   <= '0;
            frames_s1   <= '0;
        end else begin
            frame_trunc <= trunc_c;
            ifg_cnt     <= (state == IFG) ? ifg_cnt + IFG_W'(1) : '0;

            if (grant_load) begin
                grant      <= pick_port ? 2'b10 : 2'b01;
                last_grant <= pick_port;
            end else if (frame_done || drain_done) begin
                grant <= '0;
            end

            if (beat_hs) begin
                byte_cnt <= (frame_done || trunc_c) ? '0 : byte_cnt + CNT_W'(1);
            end

            if (frame_done) begin
                if (grant[1]) begin
                    frames_s1 <= frames_s1 + CNT_W'(1);
                end else begin
                    frames_s0 <= frames_s0 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_tx_arbiter.sv
// Bench for the TX arbiter: two instances (round-robin with MAX_FRAME=500 and
// IFG=12; fixed priority with MAX_FRAME=1518 and IFG=5) fed from byte queues,
// compared every cycle against a frame-level reference model.
module tb_kc705_ethernet_rgmii_axi_tx_arbiter;

    logic                  clk;
    logic                  rst;
    logic [1:0]            en;
    logic [1:0][1:0][7:0]  s_tdata;
    logic [1:0][1:0]       s_tvalid;
    logic [1:0][1:0]       s_tlast;
    wire  [1:0][1:0]       s_tready;
    wire  [1:0][7:0]       tx_tdata;
    wire  [1:0]            tx_tvalid;
    wire  [1:0]            tx_tlast;
    logic [1:0]            tx_tready;
    wire  [1:0][1:0]       grant;
    wire  [1:0]            trunc;
    wire  [1:0][15:0]      fr0;
    wire  [1:0][15:0]      fr1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        kc705_ethernet_rgmii_axi_tx_arbiter #(
            .ARB_MODE  (g == 1 ? 1'b1 : 1'b0),
            .IFG_CYCLES(g == 0 ? 8'd12 : 8'd5),
            .MAX_FRAME (g == 0 ? 16'd500 : 16'd1518)
        ) dut (
            .axi_tclk      (clk),
            .axi_treset    (rst),
            .enable_tx_arb (en[g]),
            .s0_axis_tdata (s_tdata[g][0]),
            .s0_axis_tvalid(s_tvalid[g][0]),
            .s0_axis_tlast (s_tlast[g][0]),
            .s0_axis_tready(s_tready[g][0]),
            .s1_axis_tdata (s_tdata[g][1]),
            .s1_axis_tvalid(s_tvalid[g][1]),
            .s1_axis_tlast (s_tlast[g][1]),
            .s1_axis_tready(s_tready[g][1]),
            .tx_axis_tdata (tx_tdata[g]),
            .tx_axis_tvalid(tx_tvalid[g]),
            .tx_axis_tlast (tx_tlast[g]),
            .tx_axis_tready(tx_tready[g]),
            .grant         (grant[g]),
            .frame_trunc   (trunc[g]),
            .frames_s0     (fr0[g]),
            .frames_s1     (fr1[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;

    // Source byte queues, index d*2+p; bit 8 marks the last byte of a frame.
    logic [8:0] srcq [4][$];
    bit         vhold [4];
    bit         popped [4];

    // Reference model per instance.
    bit m_busy [2];
    bit m_drain [2];
    int m_owner [2];
    int m_last [2];
    int m_beats [2];
    int m_ready [2];
    int m_trunc_cyc [2];
    int m_fr [4];

    int tr_mode;
    int gap_pct;
    int en_pct;
    int stall_at;
    int stall_left;

    logic [1:0] prev_grant [2];
    logic [1:0] glog [2][$];
    int         trunc_obs [2];
    int         beats_obs [2];

    function automatic int ifg_of(input int d);
        return (d == 0) ? 12 : 5;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? 500 : 1518;
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit all_done();
        for (int k = 0; k < 4; k++) if (srcq[k].size() > 0) return 1'b0;
        for (int d = 0; d < 2; d++) if (m_busy[d]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_frame(input int d, input int p, input int len);
        for (int i = 0; i < len; i++)
            srcq[d*2+p].push_back({1'(i == len - 1), 8'($urandom)});
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            glog[d].delete();
            trunc_obs[d] = 0;
            beats_obs[d] = 0;
        end
    endtask

    // One cycle of the expected behaviour, judged from what the bench drives.
    task automatic model_step(input int d);
        int         o;
        int         k;
        int         w;
        logic [8:0] h;
        logic       v0;
        logic       v1;
        v0 = s_tvalid[d][0];
        v1 = s_tvalid[d][1];
        check($sformatf("d%0d frame_trunc", d), 32'(trunc[d]), 32'(cyc == m_trunc_cyc[d]));
        check($sformatf("d%0d frames_s0", d), 32'(fr0[d]), 32'(16'(m_fr[d*2])));
        check($sformatf("d%0d frames_s1", d), 32'(fr1[d]), 32'(16'(m_fr[d*2+1])));
        if (!m_busy[d]) begin
            check($sformatf("d%0d idle tvalid", d), 32'(tx_tvalid[d]), 32'd0);
            check($sformatf("d%0d idle tlast", d), 32'(tx_tlast[d]), 32'd0);
            check($sformatf("d%0d idle tready", d), 32'(s_tready[d]), 32'd0);
            check($sformatf("d%0d idle grant", d), 32'(grant[d]), 32'd0);
            if (cyc >= m_ready[d] && en[d] && (v0 || v1)) begin
                if (d == 1)            w = v0 ? 0 : 1;
                else if (v0 && v1)     w = 1 - m_last[d];
                else                   w = v1 ? 1 : 0;
                m_last[d]  = w;
                m_owner[d] = w;
                m_busy[d]  = 1'b1;
                m_drain[d] = 1'b0;
                m_beats[d] = 0;
            end
        end else begin
            o = m_owner[d];
            k = d*2 + o;
            check($sformatf("d%0d grant", d), 32'(grant[d]), 32'(onehot(o)));
            check($sformatf("d%0d other tready", d), 32'(s_tready[d][1-o]), 32'd0);
            if (!m_drain[d]) begin
                check($sformatf("d%0d tvalid", d), 32'(tx_tvalid[d]), 32'(s_tvalid[d][o]));
                check($sformatf("d%0d sel tready", d), 32'(s_tready[d][o]), 32'(tx_tready[d]));
                if (s_tvalid[d][o]) begin
                    h = srcq[k][0];
                    check($sformatf("d%0d tdata", d), 32'(tx_tdata[d]), 32'(h[7:0]));
                    check($sformatf("d%0d tlast", d), 32'(tx_tlast[d]),
                          32'(h[8] || (m_beats[d] == max_of(d) - 1)));
                    if (tx_tready[d]) begin
                        void'(srcq[k].pop_front());
                        popped[k] = 1'b1;
                        m_beats[d]++;
                        if (h[8]) begin
                            m_fr[k]++;
                            m_busy[d]  = 1'b0;
                            m_ready[d] = cyc + ifg_of(d) + 1;
                        end else if (m_beats[d] == max_of(d)) begin
                            m_trunc_cyc[d] = cyc + 1;
                            m_drain[d]     = 1'b1;
                        end
                    end
                end
            end else begin
                check($sformatf("d%0d drain tvalid", d), 32'(tx_tvalid[d]), 32'd0);
                check($sformatf("d%0d drain tready", d), 32'(s_tready[d][o]), 32'd1);
                if (s_tvalid[d][o]) begin
                    h = srcq[k][0];
                    void'(srcq[k].pop_front());
                    popped[k] = 1'b1;
                    if (h[8]) begin
                        m_busy[d]  = 1'b0;
                        m_drain[d] = 1'b0;
                        m_ready[d] = cyc + ifg_of(d) + 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        rst = 1'b0;
        if (cyc == stall_at) stall_left = 256;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                int   k;
                logic v;
                k = d*2 + p;
                if (vhold[k]) v = 1'b1;
                else          v = (srcq[k].size() > 0) && ($urandom_range(99) >= gap_pct);
                s_tvalid[d][p] = v;
                if (v) begin
                    s_tdata[d][p] = srcq[k][0][7:0];
                    s_tlast[d][p] = srcq[k][0][8];
                end else begin
                    s_tdata[d][p] = 8'($urandom);
                    s_tlast[d][p] = 1'($urandom);
                end
                popped[k] = 1'b0;
            end
            case (tr_mode)
                1:       tx_tready[d] = 1'(cyc & 1);
                2:       tx_tready[d] = 1'($urandom_range(1));
                default: tx_tready[d] = 1'b1;
            endcase
            if (stall_left > 0) tx_tready[d] = 1'b0;
            en[d] = ($urandom_range(99) < en_pct);
        end
        if (stall_left > 0) stall_left--;
        #1;
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            if (grant[d] != 2'b00 && prev_grant[d] == 2'b00) glog[d].push_back(grant[d]);
            prev_grant[d] = grant[d];
            if (trunc[d]) trunc_obs[d]++;
            if (tx_tvalid[d] && tx_tready[d]) beats_obs[d]++;
        end
        for (int k = 0; k < 4; k++) vhold[k] = s_tvalid[k/2][k%2] && !popped[k];
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            s_tvalid  = '0;
            s_tlast   = '0;
            s_tdata   = '0;
            tx_tready = '1;
            en        = '0;
            #1;
            cyc++;
        end
        for (int k = 0; k < 4; k++) begin
            srcq[k].delete();
            vhold[k] = 1'b0;
            m_fr[k]  = 0;
        end
        for (int d = 0; d < 2; d++) begin
            m_busy[d]      = 1'b0;
            m_drain[d]     = 1'b0;
            m_owner[d]     = 0;
            m_last[d]      = 1;
            m_beats[d]     = 0;
            m_ready[d]     = cyc;
            m_trunc_cyc[d] = -1;
            prev_grant[d]  = 2'b00;
        end
    endtask

    task automatic run_frames(input string name, input int limit);
        int start;
        bit ok;
        start = cyc;
        while (!all_done() && (cyc - start) < limit) cycle();
        ok = all_done();
        check({name, " completes"}, 32'(ok), 32'd1);
        if (!ok) do_reset(2);
        repeat (16) cycle();
    endtask

    function automatic logic [1:0] glog_at(input int d, input int i);
        return (i < glog[d].size()) ? glog[d][i] : 2'b00;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        rst        = 1'b1;
        en         = '0;
        s_tdata    = '0;
        s_tvalid   = '0;
        s_tlast    = '0;
        tx_tready  = '0;
        tr_mode    = 0;
        gap_pct    = 0;
        en_pct     = 100;
        stall_at   = -1;
        stall_left = 0;
        do_reset(3);

        // Single 64-byte frame on port 0.
        clear_obs();
        for (int d = 0; d < 2; d++) add_frame(d, 0, 64);
        run_frames("t1", 2000);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t1 d%0d beats", d), 32'(beats_obs[d]), 32'd64);
            check($sformatf("t1 d%0d frames_s0", d), 32'(fr0[d]), 32'd1);
            check($sformatf("t1 d%0d first grant", d), 32'(glog_at(d, 0)), 32'(2'b01));
        end

        // Both ports continuously valid, four 100-byte frames each.
        clear_obs();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                for (int f = 0; f < 4; f++) add_frame(d, p, 100);
        run_frames("t2", 20000);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2 rr grant %0d", i), 32'(glog_at(0, i)),
                  32'((i % 2 == 0) ? 2'b10 : 2'b01));
            check($sformatf("t2 fp grant %0d", i), 32'(glog_at(1, i)),
                  32'((i < 4) ? 2'b01 : 2'b10));
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t2 d%0d frames_s0", d), 32'(fr0[d]), 32'd5);
            check($sformatf("t2 d%0d frames_s1", d), 32'(fr1[d]), 32'd4);
        end

        // 600-byte frame on port 1: truncated at 500 on the round-robin instance.
        clear_obs();
        for (int d = 0; d < 2; d++) add_frame(d, 1, 600);
        run_frames("t4", 20000);
        check("t4 d0 beats", 32'(beats_obs[0]), 32'd500);
        check("t4 d0 trunc pulses", 32'(trunc_obs[0]), 32'd1);
        check("t4 d0 frames_s1", 32'(fr1[0]), 32'd4);
        check("t4 d1 beats", 32'(beats_obs[1]), 32'd600);
        check("t4 d1 trunc pulses", 32'(trunc_obs[1]), 32'd0);
        check("t4 d1 frames_s1", 32'(fr1[1]), 32'd5);

        // Lengths around MAX_FRAME: 499, 500 (tlast on the last allowed byte), 501.
        clear_obs();
        for (int d = 0; d < 2; d++) begin
            add_frame(d, 0, 499);
            add_frame(d, 0, 500);
            add_frame(d, 0, 501);
        end
        run_frames("t4b", 20000);
        check("t4b d0 beats", 32'(beats_obs[0]), 32'd1499);
        check("t4b d0 trunc pulses", 32'(trunc_obs[0]), 32'd1);
        check("t4b d0 frames_s0", 32'(fr0[0]), 32'd7);
        check("t4b d1 beats", 32'(beats_obs[1]), 32'd1500);
        check("t4b d1 frames_s0", 32'(fr0[1]), 32'd8);

        // tx_tready toggling every cycle with a 256-cycle stall mid-frame.
        clear_obs();
        tr_mode  = 1;
        stall_at = cyc + 60;
        for (int d = 0; d < 2; d++) begin
            add_frame(d, 0, 150);
            add_frame(d, 1, 120);
        end
        run_frames("t5a", 5000);
        check("t5a d0 beats", 32'(beats_obs[0]), 32'd270);
        check("t5a d1 beats", 32'(beats_obs[1]), 32'd270);
        stall_at = -1;

        // Randomized lengths, source gaps, tready and enable.
        tr_mode = 2;
        gap_pct = 30;
        en_pct  = 85;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                for (int f = 0; f < 10; f++)
                    add_frame(d, p, ($urandom_range(3) == 0) ? int'($urandom_range(560, 450))
                                                             : int'($urandom_range(60, 1)));
        run_frames("t5b", 40000);
        tr_mode = 0;
        gap_pct = 0;
        en_pct  = 100;

        // Reset at byte 30 of a frame, then the first tie goes to port 0.
        clear_obs();
        for (int d = 0; d < 2; d++) add_frame(d, 0, 64);
        guard = 0;
        while (beats_obs[0] < 30 && guard < 500) begin
            cycle();
            guard++;
        end
        check("t6 bytes before reset", 32'(beats_obs[0]), 32'd30);
        do_reset(1);
        cycle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t6 d%0d tdata", d), 32'(tx_tdata[d]), 32'd0);
            check($sformatf("t6 d%0d tvalid", d), 32'(tx_tvalid[d]), 32'd0);
            check($sformatf("t6 d%0d grant", d), 32'(grant[d]), 32'd0);
            check($sformatf("t6 d%0d frames_s0", d), 32'(fr0[d]), 32'd0);
            check($sformatf("t6 d%0d frames_s1", d), 32'(fr1[d]), 32'd0);
        end
        clear_obs();
        for (int d = 0; d < 2; d++) begin
            add_frame(d, 0, 20);
            add_frame(d, 1, 20);
        end
        run_frames("t6", 2000);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t6 d%0d tie grant", d), 32'(glog_at(d, 0)), 32'(2'b01));
            check($sformatf("t6 d%0d second grant", d), 32'(glog_at(d, 1)), 32'(2'b10));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
